// File: rtl/bcd_down_counter.sv
// Cascadable multi-digit BCD down counter with clamped parallel load, ET/EP enables,
// combinational borrow-out and registered done / load_err pulses.
module bcd_down_counter #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                CR,
  input  logic                LD_n,
  input  logic                ET,
  input  logic                EP,
  input  logic [4*DIGITS-1:0] D,
  output logic [4*DIGITS-1:0] Q,
  output logic                bo,
  output logic                zero,
  output logic                done,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ZEROS = {W{1'b0}};
  localparam logic [W-1:0] NINES = {DIGITS{4'd9}};

  logic [W-1:0] dec_val;
  logic [W-1:0] load_val;
  logic         load_bad;

  function automatic logic [3:0] clamp_digit(input logic [3:0] dig);
    return (dig > 4'd9) ? 4'd9 : dig;
  endfunction

  // Ripple-borrow decrement of the current state and clamped load value
  always_comb begin
    logic borrow;
    borrow   = 1'b1;
    dec_val  = ZEROS;
    load_val = ZEROS;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (Q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = Q[4*i +: 4] - 4'd1;
        end
      end else begin
        dec_val[4*i +: 4] = Q[4*i +: 4];
      end
      borrow            = borrow & (Q[4*i +: 4] == 4'd0);
      load_val[4*i +: 4] = clamp_digit(D[4*i +: 4]);
      load_bad          = load_bad | (D[4*i +: 4] > 4'd9);
    end
  end

  assign zero = (Q == ZEROS);
  assign bo   = ET & zero;

  // State and pulse registers; priority is clear, load, count, hold
  always_ff @(posedge clk) begin
    if (CR) begin
      Q        <= ZEROS;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else if (!LD_n) begin
      Q        <= load_val;
      done     <= 1'b0;
      load_err <= load_bad;
    end else if (ET && EP) begin
      load_err <= 1'b0;
      if (zero) begin
        // The all-zero step is never a "counted arrival" at zero
        Q    <= WRAP ? NINES : ZEROS;
        done <= 1'b0;
      end else begin
        Q    <= dec_val;
        done <= (dec_val == ZEROS);
      end
    end else begin
      Q        <= Q;
      done     <= 1'b0;
      load_err <= 1'b0;
    end
  end

endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Cascadable multi-digit BCD down counter. It is the count-down counterpart of the team's decade up-counter, with the same control style: a load input, ET/EP enables and a ripple output.
- Used for countdown timers in the counter modules, for example the minute and second displays of a preset-and-countdown clock.
- The ripple output is a borrow, so stages chain toward lower significance-to-higher significance exactly as the up-counters do with their carry output.

Parameters:
- DIGITS, 2: number of BCD digits; Q width is 4*DIGITS.
- WRAP, 1: 1 = all-zero decrements to all-nines; 0 = counter holds at zero, further count enables are ignored.

Ports:
- clk  in  1  rising-edge clock.
- CR  in  1  synchronous active-high clear.
- LD_n  in  1  synchronous active-low parallel load.
- ET  in  1  count enable; also gates bo.
- EP  in  1  count enable.
- D  in  4*DIGITS  load value; digit i occupies bits [4i+3:4i], digit 0 is least significant.
- Q  out  4*DIGITS  counter state, BCD, same packing as D.
- bo  out  1  borrow out, combinational: ET & (Q == 0). Drives ET of the next, more significant stage.
- zero  out  1  combinational: Q == 0.
- done  out  1  registered one-cycle pulse on a counted transition to zero.
- load_err  out  1  registered one-cycle pulse when a load contained a non-BCD digit.

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - Reset is synchronous and active-high; CR is sampled only at the clock edge.
- Priority per edge: CR, then load (LD_n == 0), then count (ET & EP), otherwise hold.
- CR = 1:
  - Q = 0, done = 0, load_err = 0.
  - bo then equals ET and zero = 1.
- Load (LD_n = 0):
  - Each digit of D is copied to Q.
  - Any digit above 9 (A..F) is clamped to 9.
  - load_err = 1 on the next cycle if any digit was clamped, else 0.
  - done = 0.
  - Load overrides count even when ET = EP = 1.
- Count (ET = EP = 1, LD_n = 1, CR = 0):
  - Digit 0 decrements by 1.
  - Digit i (i > 0) decrements only when digits 0..i-1 are all 0 in the current state.
  - A digit at 0 that decrements becomes 9.
  - Decrement is BCD-correct: Q never holds A..F.
- All-zero boundary with count asserted:
  - WRAP = 1: Q becomes all nines (e.g. 99 for DIGITS = 2). done stays 0.
  - WRAP = 0: Q holds at 0. done stays 0.
- done:
  - Asserted for exactly one cycle, on the cycle after a count step moves Q from a nonzero value to 0.
  - Loading 0 does not assert done.
  - Reaching 0 through CR does not assert done.
- Hold (no CR, LD_n = 1, and ET = 0 or EP = 0): Q unchanged; done = 0; load_err = 0.
- Cascading:
  - Stage n+1 takes ET from stage n's bo; EP is shared.
  - A higher stage then steps only in the cycle in which the lower stage wraps from 0 to 9.
  - The bo path is combinational from Q and ET; latency is zero from lower-stage state to higher-stage enable.
- Latency:
  - Q, done and load_err: one clock after the sampled inputs.
  - bo and zero: combinational.
- Reset mid-operation: CR wins over simultaneous load or count. A done or load_err pulse due in the same cycle is suppressed (output 0).

Test Plan (DIGITS = 2):
- Reset and basic countdown: CR = 1 for one cycle, then LD_n = 0 with D = 0x12, then ET = EP = 1 for 3 cycles.
  - Required: Q = 00 after reset; then 12, 11, 10, 09.
  - bo = 0 throughout; load_err = 0.
- Countdown to zero and wrap (WRAP = 1): load 0x02, then count 4 cycles.
  - Required: Q = 01, 00, 99, 98.
  - done = 1 only in the cycle Q first reads 00.
  - bo = 1 only while Q = 00 and ET = 1.
- Hold at zero (WRAP = 0): load 0x01, then count 3 cycles.
  - Required: Q = 00, 00, 00.
  - done pulses once; zero = 1 stays high.
- Clamp on load: LD_n = 0 with D = 0xA7.
  - Required: Q = 97; load_err = 1 for one cycle.
  - Next count: Q = 96, load_err = 0.
- Priority:
  - Q = 50, apply LD_n = 0 with D = 0x33 and ET = EP = 1 together: required Q = 33.
  - Then CR = 1 with LD_n = 0: required Q = 00, done = 0.
- Enable gating and cascade: two DIGITS = 1 instances chained bo -> ET, loaded 1 and 0 (ones digit = 0), EP = 1.
  - Required after one cycle: tens = 0, ones = 9.
  - With EP = 0: state holds for any number of cycles.
